// File: rtl/clock_set_ctrl_pkg.sv
// Shared state encoding, default timing and counter widths for the LED clock time-setting front end.
package clock_set_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2
  } set_state_e;

  localparam int unsigned DEB_CYCLES_DFLT = 655;
  localparam int unsigned REP_DELAY_DFLT  = 16384;
  localparam int unsigned REP_PERIOD_DFLT = 8192;
  localparam int unsigned BLINK_HALF_DFLT = 8192;
  localparam int unsigned TIMEOUT_DFLT    = 983040;

  localparam int DEB_W   = 10;
  localparam int REP_W   = 15;
  localparam int BLINK_W = 14;
  localparam int TO_W    = 20;

  // MODE always takes priority over the idle timeout.
  function automatic set_state_e next_state(input set_state_e st,
                                            input logic       mode_p,
                                            input logic       timeout_hit);
    set_state_e nxt;
    nxt = st;
    case (st)
      RUN:      if (mode_p) nxt = SET_HOUR;
      SET_HOUR: if (mode_p) nxt = SET_MIN;
                else if (timeout_hit) nxt = RUN;
      SET_MIN:  if (mode_p || timeout_hit) nxt = RUN;
      default:  nxt = RUN;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/clock_set_ctrl_debounce.sv
// Push-button conditioner: 2-flop synchroniser, settle down-counter, one-cycle press pulse.
module btn_debounce
  import clock_set_ctrl_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = DEB_CYCLES_DFLT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n,
  output logic level,
  output logic press
);

  logic [1:0]       sync_q;
  logic             btn_act;
  logic             btn_last;
  logic             changed;
  logic             settle;
  logic [DEB_W-1:0] deb_cnt;

  assign btn_act = ~sync_q[1];
  assign changed = btn_act ^ btn_last;
  // Counter hits 1 on the last of DEB_CYCLES equal samples.
  assign settle  = ~changed & (deb_cnt == DEB_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q   <= 2'b11;
      btn_last <= 1'b0;
      deb_cnt  <= '0;
      level    <= 1'b0;
      press    <= 1'b0;
    end else begin
      sync_q   <= {sync_q[0], btn_n};
      btn_last <= btn_act;
      press    <= settle & btn_act & ~level;
      if (changed)
        deb_cnt <= DEB_W'(DEB_CYCLES - 1);
      else if (deb_cnt != '0)
        deb_cnt <= deb_cnt - 1'b1;
      if (settle)
        level <= btn_act;
    end
  end

endmodule

// File: rtl/clock_set_ctrl.sv
// Time-setting controller: MODE/ADJ handling, auto-repeat, idle timeout, blink masks and tick gating.
//
//   state    | meaning
//   ---------+-------------------------------------------------
//   RUN      | normal timekeeping, minute tick passed through
//   SET_HOUR | ADJ increments hours, hour digits blink
//   SET_MIN  | ADJ increments minutes, minute digits blink
module clock_set_ctrl
  import clock_set_ctrl_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = DEB_CYCLES_DFLT,
  parameter int unsigned REP_DELAY  = REP_DELAY_DFLT,
  parameter int unsigned REP_PERIOD = REP_PERIOD_DFLT,
  parameter int unsigned BLINK_HALF = BLINK_HALF_DFLT,
  parameter int unsigned TIMEOUT    = TIMEOUT_DFLT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_mode_n,
  input  logic       btn_adj_n,
  input  logic       tick_in,
  output logic       tick_out,
  output logic       inc_min,
  output logic       inc_hour,
  output logic       presc_clr,
  output logic       blank_hr,
  output logic       blank_min,
  output logic [1:0] set_mode
);

  logic [1:0]         rst_sync_q;
  logic               rst_int_n;
  logic               mode_p;
  logic               mode_lvl_unused;
  logic               adj_p;
  logic               adj_lvl;
  logic               press_any;
  logic               in_set;
  logic               timeout_hit;
  logic               rep_fire;
  logic               adj_go;
  logic               phase;
  logic               phase_nxt;
  logic [REP_W-1:0]   rep_cnt;
  logic [TO_W-1:0]    to_cnt;
  logic [BLINK_W-1:0] blink_cnt;
  set_state_e         state;
  set_state_e         st_nxt;

  // Reset asserts immediately, releases on a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= 2'b00;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_int_n = rst_sync_q[1];

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_mode (
    .clk   (clk),
    .rst_n (rst_int_n),
    .btn_n (btn_mode_n),
    .level (mode_lvl_unused),
    .press (mode_p)
  );

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_adj (
    .clk   (clk),
    .rst_n (rst_int_n),
    .btn_n (btn_adj_n),
    .level (adj_lvl),
    .press (adj_p)
  );

  assign press_any   = mode_p | adj_p;
  assign in_set      = (state != RUN);
  assign timeout_hit = in_set & (to_cnt == '0) & ~press_any;
  assign st_nxt      = next_state(state, mode_p, timeout_hit);
  assign adj_go      = in_set & adj_p & ~mode_p;
  assign rep_fire    = in_set & adj_lvl & (rep_cnt == REP_W'(1)) & ~mode_p & ~timeout_hit;
  // A press restarts the blink in the visible half so the digit being edited is readable.
  assign phase_nxt   = press_any ? 1'b0 : ((blink_cnt == '0) ? ~phase : phase);

  assign tick_out = tick_in & (state == RUN);
  assign set_mode = state;

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state     <= RUN;
      inc_hour  <= 1'b0;
      inc_min   <= 1'b0;
      presc_clr <= 1'b0;
      blank_hr  <= 1'b0;
      blank_min <= 1'b0;
    end else begin
      state     <= st_nxt;
      inc_hour  <= (state == SET_HOUR) & (adj_go | rep_fire);
      inc_min   <= (state == SET_MIN) & (adj_go | rep_fire);
      presc_clr <= (state == SET_MIN) & mode_p;
      blank_hr  <= (st_nxt == SET_HOUR) & phase_nxt;
      blank_min <= (st_nxt == SET_MIN) & phase_nxt;
    end
  end

  // Repeat needs a fresh ADJ press after any MODE press or leaving SET_*.
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n)
      rep_cnt <= '0;
    else if (!in_set || !adj_lvl || mode_p || timeout_hit)
      rep_cnt <= '0;
    else if (adj_p)
      rep_cnt <= REP_W'(REP_DELAY - 1);
    else if (rep_cnt == REP_W'(1))
      rep_cnt <= REP_W'(REP_PERIOD);
    else if (rep_cnt != '0)
      rep_cnt <= rep_cnt - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n)
      to_cnt <= '0;
    else if (press_any)
      to_cnt <= TO_W'(TIMEOUT - 1);
    else if (to_cnt != '0)
      to_cnt <= to_cnt - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      blink_cnt <= '0;
      phase     <= 1'b0;
    end else begin
      phase <= phase_nxt;
      if (press_any || blink_cnt == '0)
        blink_cnt <= BLINK_W'(BLINK_HALF - 1);
      else
        blink_cnt <= blink_cnt - 1'b1;
    end
  end

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed bench for clock_set_ctrl with shortened timing parameters.
module tb_clock_set_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_mode_n = 1'b1;
  logic       btn_adj_n = 1'b1;
  logic       tick_in = 1'b0;
  logic       tick_out;
  logic       inc_min;
  logic       inc_hour;
  logic       presc_clr;
  logic       blank_hr;
  logic       blank_min;
  logic [1:0] set_mode;

  int n_chk = 0;
  int n_err = 0;

  clock_set_ctrl #(
    .DEB_CYCLES (4),
    .REP_DELAY  (20),
    .REP_PERIOD (8),
    .BLINK_HALF (6),
    .TIMEOUT    (100)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_mode_n (btn_mode_n),
    .btn_adj_n  (btn_adj_n),
    .tick_in    (tick_in),
    .tick_out   (tick_out),
    .inc_min    (inc_min),
    .inc_hour   (inc_hour),
    .presc_clr  (presc_clr),
    .blank_hr   (blank_hr),
    .blank_min  (blank_min),
    .set_mode   (set_mode)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " set_mode"}, set_mode, 0);
    chk({tag, " inc_hour"}, inc_hour, 0);
    chk({tag, " inc_min"}, inc_min, 0);
    chk({tag, " presc_clr"}, presc_clr, 0);
    chk({tag, " blank_hr"}, blank_hr, 0);
    chk({tag, " blank_min"}, blank_min, 0);
    chk({tag, " tick_out"}, tick_out, 0);
  endtask

  // Button driven at cycle 0; press event lands in cycle 6, new state visible in cycle 7.
  task automatic mode_press(input int prev_st, input int exp_st, input bit exp_clr);
    btn_mode_n = 1'b0;
    for (int c = 1; c <= 22; c++) begin
      @(negedge clk);
      chk($sformatf("mode_st c%0d", c), set_mode, (c >= 7) ? exp_st : prev_st);
      chk($sformatf("presc_clr c%0d", c), presc_clr, (exp_clr && c == 7) ? 1 : 0);
      chk($sformatf("mode_inc c%0d", c), {30'd0, inc_hour, inc_min}, 0);
      if (c == 10) btn_mode_n = 1'b1;
      if (c == 15) begin
        tick_in = 1'b1;
        #1;
        chk($sformatf("tick_out st%0d", exp_st), tick_out, (exp_st == 0) ? 1 : 0);
        tick_in = 1'b0;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "bench did not complete");
  end

  initial begin
    cyc(3);
    chk_all_zero("reset");
    rst_n = 1'b1;
    cyc(5);

    // Three-cycle glitch on MODE must not register.
    btn_mode_n = 1'b0;
    cyc(3);
    btn_mode_n = 1'b1;
    cyc(12);
    chk("glitch st", set_mode, 0);

    mode_press(0, 1, 1'b0);

    // Held ADJ in SET_HOUR: press event at cycle 6, pulses at offsets 1,20,28,36,44.
    btn_adj_n = 1'b0;
    for (int c = 1; c <= 70; c++) begin
      @(negedge clk);
      chk($sformatf("rep inc_hour c%0d", c), inc_hour,
          (c == 7 || c == 26 || c == 34 || c == 42 || c == 50) ? 1 : 0);
      chk($sformatf("rep inc_min c%0d", c), inc_min, 0);
      if (c == 51) btn_adj_n = 1'b1;
    end
    chk("rep st", set_mode, 1);

    // MODE+ADJ together, then idle in SET_MIN until timeout.
    btn_mode_n = 1'b0;
    btn_adj_n  = 1'b0;
    for (int c = 1; c <= 112; c++) begin
      @(negedge clk);
      if (c == 20) begin
        btn_mode_n = 1'b1;
        btn_adj_n  = 1'b1;
      end
      if (c == 6) chk("both st pre", set_mode, 1);
      if (c >= 7) begin
        chk($sformatf("both st c%0d", c), set_mode, (c <= 106) ? 2 : 0);
        chk($sformatf("blank_min c%0d", c), blank_min, (c <= 106) ? ((c - 7) / 6) % 2 : 0);
        chk($sformatf("both blank_hr c%0d", c), blank_hr, 0);
        chk($sformatf("both inc c%0d", c), {30'd0, inc_hour, inc_min}, 0);
        chk($sformatf("to presc_clr c%0d", c), presc_clr, 0);
      end
    end

    mode_press(0, 1, 1'b0);
    mode_press(1, 2, 1'b0);
    mode_press(2, 0, 1'b1);

    // Reset in SET_MIN with ADJ still held.
    mode_press(0, 1, 1'b0);
    mode_press(1, 2, 1'b0);
    btn_adj_n = 1'b0;
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      chk($sformatf("min inc_min c%0d", c), inc_min, (c == 7) ? 1 : 0);
      chk($sformatf("min inc_hour c%0d", c), inc_hour, 0);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_all_zero("mid reset");
    cyc(3);
    rst_n = 1'b1;
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      chk($sformatf("post rst inc c%0d", c), {30'd0, inc_hour, inc_min}, 0);
      chk($sformatf("post rst st c%0d", c), set_mode, 0);
    end
    btn_adj_n = 1'b1;
    cyc(10);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
